press_game_ctrl: RTL and testbench

Frame sequencer for the garbage-press game. Sits directly upstream of `draw`: it converts rate-divider ticks and the hit key into an ordered series of draw commands (garbage, erase old press, draw new press, erase hit garbage). It owns press motion, garbage spawning and the score, and waits on `draw` completion instead of counting fixed clock delays. Score feeds the two `hex_decoder` instances.

---
 rtl/press_game_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_press_game_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_game_ctrl.sv
// press_game_ctrl: frame sequencer for the garbage-press game.
// Turns frame ticks and the hit key into ordered draw commands, waits on
// draw_done for each one, and owns press motion, garbage spawning and score.
module press_game_ctrl #(
    parameter logic [7:0] SCORE_MAX = 8'd255,
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       hit_n,
    input  logic       draw_done,
    output logic       draw_go,
    output logic       item,
    output logic       erase,
    output logic [1:0] position,
    output logic [1:0] press_pos,
    output logic       garb_valid,
    output logic [1:0] garb_pos,
    output logic [7:0] score,
    output logic       busy
);

    typedef enum logic [3:0] {
        StIdle, StSpawn, StGGo, StGWait, StEGo, StEWait, StPGo, StPWait, StHGo, StHWait
    } state_e;

    state_e state_q, state_d;

    logic [7:0] lfsr_q, lfsr_d;
    logic       hit_s1_q, hit_s2_q, hit_s3_q;
    logic       hit_pend_q, hit_pend_d;
    logic       tick_pend_q, tick_pend_d;
    logic [1:0] press_pos_q, press_pos_d;
    logic [1:0] prev_pos_q, prev_pos_d;
    logic       dir_up_q, dir_up_d;
    logic       garb_valid_q, garb_valid_d;
    logic [1:0] garb_pos_q, garb_pos_d;
    logic [7:0] score_q, score_d;
    logic       draw_go_q, draw_go_d;
    logic       item_q, item_d;
    logic       erase_q, erase_d;
    logic [1:0] position_q, position_d;

    logic hit_fall, hit_evt, tick_evt, hit_match;

    // hit_s3_q is the previous synchronized level, used only for fall detection.
    assign hit_fall  = hit_s3_q & ~hit_s2_q;
    // A fall detected this cycle counts as pending so it wins over a same-cycle tick.
    assign hit_evt   = hit_pend_q | hit_fall;
    assign tick_evt  = tick_pend_q | tick;
    assign hit_match = garb_valid_q && (press_pos_q == garb_pos_q);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: hits before ticks, every *_WAIT holds until draw_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (hit_evt) begin
                    state_d = hit_match ? StHGo : StIdle;
                end else if (tick_evt) begin
                    state_d = StSpawn;
                end
            end
            StSpawn: state_d = StGGo;
            StGGo:   state_d = StGWait;
            StGWait: if (draw_done) state_d = StEGo;
            StEGo:   state_d = StEWait;
            StEWait: if (draw_done) state_d = StPGo;
            StPGo:   state_d = StPWait;
            StPWait: if (draw_done) state_d = StIdle;
            StHGo:   state_d = StHWait;
            StHWait: if (draw_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Game state next values: LFSR, pending flags, garbage, motion and score.
    always_comb begin
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        hit_pend_d   = hit_pend_q | hit_fall;
        tick_pend_d  = tick_pend_q | tick;
        press_pos_d  = press_pos_q;
        prev_pos_d   = prev_pos_q;
        dir_up_d     = dir_up_q;
        garb_valid_d = garb_valid_q;
        garb_pos_d   = garb_pos_q;
        score_d      = score_q;
        case (state_q)
            StIdle: begin
                if (hit_evt) begin
                    hit_pend_d = 1'b0;
                end else if (tick_evt) begin
                    tick_pend_d = 1'b0;
                end
            end
            StSpawn: begin
                if (!garb_valid_q) begin
                    garb_pos_d   = lfsr_q[1:0];
                    garb_valid_d = 1'b1;
                end
            end
            StGWait: begin
                if (draw_done) begin
                    prev_pos_d = press_pos_q;
                    if (press_pos_q == 2'd3) begin
                        dir_up_d    = 1'b0;
                        press_pos_d = 2'd2;
                    end else if (press_pos_q == 2'd0) begin
                        dir_up_d    = 1'b1;
                        press_pos_d = 2'd1;
                    end else begin
                        press_pos_d = dir_up_q ? press_pos_q + 2'd1 : press_pos_q - 2'd1;
                    end
                end
            end
            StHWait: begin
                if (draw_done) begin
                    garb_valid_d = 1'b0;
                    score_d      = (score_q >= SCORE_MAX) ? score_q : score_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Command outputs: loaded on entry to a *_GO state, held through its *_WAIT.
    always_comb begin
        draw_go_d  = 1'b0;
        item_d     = item_q;
        erase_d    = erase_q;
        position_d = position_q;
        case (state_d)
            StGGo: begin
                draw_go_d  = 1'b1;
                item_d     = 1'b0;
                erase_d    = 1'b0;
                position_d = garb_pos_d;
            end
            StEGo: begin
                draw_go_d  = 1'b1;
                item_d     = 1'b1;
                erase_d    = 1'b1;
                position_d = prev_pos_d;
            end
            StPGo: begin
                draw_go_d  = 1'b1;
                item_d     = 1'b1;
                erase_d    = 1'b0;
                position_d = press_pos_q;
            end
            StHGo: begin
                draw_go_d  = 1'b1;
                item_d     = 1'b0;
                erase_d    = 1'b1;
                position_d = garb_pos_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers; the key synchronizer idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q       <= LFSR_SEED;
            hit_s1_q     <= 1'b1;
            hit_s2_q     <= 1'b1;
            hit_s3_q     <= 1'b1;
            hit_pend_q   <= 1'b0;
            tick_pend_q  <= 1'b0;
            press_pos_q  <= 2'd1;
            prev_pos_q   <= 2'd0;
            dir_up_q     <= 1'b1;
            garb_valid_q <= 1'b0;
            garb_pos_q   <= 2'd0;
            score_q      <= 8'd0;
            draw_go_q    <= 1'b0;
            item_q       <= 1'b0;
            erase_q      <= 1'b0;
            position_q   <= 2'd0;
        end else begin
            lfsr_q       <= lfsr_d;
            hit_s1_q     <= hit_n;
            hit_s2_q     <= hit_s1_q;
            hit_s3_q     <= hit_s2_q;
            hit_pend_q   <= hit_pend_d;
            tick_pend_q  <= tick_pend_d;
            press_pos_q  <= press_pos_d;
            prev_pos_q   <= prev_pos_d;
            dir_up_q     <= dir_up_d;
            garb_valid_q <= garb_valid_d;
            garb_pos_q   <= garb_pos_d;
            score_q      <= score_d;
            draw_go_q    <= draw_go_d;
            item_q       <= item_d;
            erase_q      <= erase_d;
            position_q   <= position_d;
        end
    end

    assign draw_go    = draw_go_q;
    assign item       = item_q;
    assign erase      = erase_q;
    assign position   = position_q;
    assign press_pos  = press_pos_q;
    assign garb_valid = garb_valid_q;
    assign garb_pos   = garb_pos_q;
    assign score      = score_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_press_game_ctrl.sv
// Bench for press_game_ctrl: event-level game model plus per-cycle command checker.
module tb_press_game_ctrl;

    localparam logic [7:0] SEED = 8'h01;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       hit_n;
    logic       draw_done;
    logic       draw_go;
    logic       item;
    logic       erase;
    logic [1:0] position;
    logic [1:0] press_pos;
    logic       garb_valid;
    logic [1:0] garb_pos;
    logic [7:0] score;
    logic       busy;

    press_game_ctrl #(
        .SCORE_MAX(8'd255),
        .LFSR_SEED(SEED)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .hit_n     (hit_n),
        .draw_done (draw_done),
        .draw_go   (draw_go),
        .item      (item),
        .erase     (erase),
        .position  (position),
        .press_pos (press_pos),
        .garb_valid(garb_valid),
        .garb_pos  (garb_pos),
        .score     (score),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       item;
        logic       erase;
        logic [1:0] pos;
        logic       spawn;
    } cmd_t;

    int checks = 0;
    int errors = 0;

    // Model state: press bounces through a fixed 6-step cycle starting at slot 1.
    int         seq [6] = '{1, 2, 3, 2, 1, 0};
    int         ph;
    bit         mgv;
    logic [1:0] mgpos;
    int         mscore;
    cmd_t       exp_q[$];
    logic [7:0] lfsr_m, lfsr_prev;
    bit         lfsr_hold;
    bit         active;
    cmd_t       held;
    cmd_t       e;
    logic [1:0] ep;
    int         go_count = 0;
    logic [1:0] last_erase;
    bit         resp_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [1:0] cur_press();
        return 2'(seq[ph]);
    endfunction

    task automatic push_cmd(input logic it, input logic er, input logic [1:0] p, input logic sp);
        cmd_t c;
        c.item = it; c.erase = er; c.pos = p; c.spawn = sp;
        exp_q.push_back(c);
    endtask

    task automatic model_frame();
        if (!mgv) begin
            push_cmd(1'b0, 1'b0, 2'd0, 1'b1);
            mgv = 1'b1;
        end else begin
            push_cmd(1'b0, 1'b0, mgpos, 1'b0);
        end
        push_cmd(1'b1, 1'b1, cur_press(), 1'b0);
        ph = (ph + 1) % 6;
        push_cmd(1'b1, 1'b0, cur_press(), 1'b0);
    endtask

    task automatic model_hit();
        if (mgv && cur_press() == mgpos) begin
            push_cmd(1'b0, 1'b1, mgpos, 1'b0);
            mgv = 1'b0;
            if (mscore < 255) mscore++;
        end
    endtask

    task automatic model_reset();
        ph = 0; mgv = 1'b0; mgpos = 2'd0; mscore = 0;
        exp_q.delete();
    endtask

    // Compare process: checks every command strobe and that fields hold until draw_done.
    always @(negedge clock) begin
        if (reset) begin
            lfsr_m = SEED;
            lfsr_hold = 1'b1;
            active = 1'b0;
        end else begin
            lfsr_prev = lfsr_m;
            if (lfsr_hold) lfsr_hold = 1'b0;
            else lfsr_m = lfsr_step(lfsr_m);
            if (active) begin
                chk("hold_item", item, held.item);
                chk("hold_erase", erase, held.erase);
                chk("hold_pos", position, held.pos);
                chk("busy_in_wait", busy, 1);
                if (draw_done) active = 1'b0;
            end
            if (draw_go) begin
                go_count++;
                if (active) begin
                    checks++; errors++;
                    $display("FAIL go_overlap: draw_go while previous command still open");
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_go: item %0d erase %0d pos %0d, expected no command",
                             item, erase, position);
                end else begin
                    e  = exp_q.pop_front();
                    // A spawning frame takes the LFSR value of the cycle before G_GO.
                    ep = e.spawn ? lfsr_prev[1:0] : e.pos;
                    if (e.spawn) mgpos = ep;
                    chk("cmd_item", item, e.item);
                    chk("cmd_erase", erase, e.erase);
                    chk("cmd_pos", position, ep);
                    chk("busy_in_go", busy, 1);
                    if (item && erase) last_erase = position;
                    held.item = e.item; held.erase = e.erase; held.pos = ep; held.spawn = 1'b0;
                    active = 1'b1;
                end
            end
        end
    end

    // draw stand-in: answers each command three cycles after its strobe.
    initial begin
        draw_done = 1'b0;
        forever begin
            @(negedge clock);
            if (draw_go && resp_en && !reset) begin
                repeat (3) @(posedge clock);
                #1 draw_done = 1'b1;
                @(posedge clock);
                #1 draw_done = 1'b0;
            end
        end
    end

    task automatic pulse_tick();
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
    endtask

    task automatic pulse_hit();
        @(posedge clock); #1 hit_n = 1'b0;
        repeat (4) @(posedge clock);
        #1 hit_n = 1'b1;
    endtask

    task automatic wait_go();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!draw_go && n < 60);
        if (!draw_go) begin
            checks++; errors++;
            $display("FAIL go_timeout: no draw_go within %0d cycles", n);
        end
    endtask

    task automatic wait_idle();
        int n;
        repeat (3) @(negedge clock);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy %0d, %0d commands outstanding", busy, exp_q.size());
        end
        chk("press_pos", press_pos, cur_press());
        chk("garb_valid", garb_valid, mgv);
        if (mgv) chk("garb_pos", garb_pos, mgpos);
        chk("score", score, mscore);
        chk("busy_idle", busy, 0);
    endtask

    task automatic do_tick();
        model_frame();
        pulse_tick();
        wait_idle();
    endtask

    task automatic do_hit();
        model_hit();
        pulse_hit();
        wait_idle();
    endtask

    int exp_press [5] = '{2, 3, 2, 1, 0};
    int exp_erase [5] = '{1, 2, 3, 2, 1};
    int g0;
    int iter;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; hit_n = 1'b1; resp_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_draw_go", draw_go, 0);
        chk("rst_item", item, 0);
        chk("rst_erase", erase, 0);
        chk("rst_position", position, 0);
        chk("rst_press_pos", press_pos, 1);
        chk("rst_garb_valid", garb_valid, 0);
        chk("rst_garb_pos", garb_pos, 0);
        chk("rst_score", score, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); #1 reset = 1'b0;

        // First frame: exact tick-to-strobe latency; seed 01 gives LFSR 04 at SPAWN.
        g0 = go_count;
        model_frame();
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        @(negedge clock);
        chk("spawn_cycle_go", draw_go, 0);
        chk("spawn_cycle_busy", busy, 1);
        @(negedge clock);
        chk("g_go_cycle", draw_go, 1);
        wait_idle();
        chk("first_spawn_pos", garb_pos, 0);
        chk("frame0_gos", go_count - g0, 3);
        chk("frame0_press", press_pos, exp_press[0]);
        chk("frame0_erase", last_erase, exp_erase[0]);

        for (int i = 1; i < 5; i++) begin
            g0 = go_count;
            do_tick();
            chk("frame_gos", go_count - g0, 3);
            chk("frame_press", press_pos, exp_press[i]);
            chk("frame_erase", last_erase, exp_erase[i]);
        end
        chk("garb_pos_stable", garb_pos, 0);

        // Press now at 0, garbage at 0: a scoring hit.
        do_hit();
        chk("hit_score", score, 1);
        chk("hit_clears_garb", garb_valid, 0);
        do_tick();
        chk("respawn", garb_valid, 1);

        // Miss.
        iter = 0;
        while (!(mgv && cur_press() != mgpos) && iter < 12) begin do_tick(); iter++; end
        g0 = go_count;
        do_hit();
        chk("miss_no_go", go_count - g0, 0);
        chk("miss_score", score, 1);

        // Hit fall detected in the same cycle a tick arrives: hit first, then one frame.
        iter = 0;
        while (!(mgv && cur_press() == mgpos) && iter < 12) begin do_tick(); iter++; end
        model_hit();
        model_frame();
        g0 = go_count;
        @(posedge clock); #1 hit_n = 1'b0;
        @(posedge clock);
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        repeat (2) @(posedge clock);
        #1 hit_n = 1'b1;
        wait_idle();
        chk("same_cycle_gos", go_count - g0, 4);
        chk("same_cycle_score", score, 2);

        // Hit and extra ticks during G_WAIT: frame, then hit on updated press, then one frame.
        iter = 0;
        while (!(mgv && 2'(seq[(ph + 1) % 6]) == mgpos) && iter < 12) begin
            do_tick(); iter++;
        end
        model_frame();
        model_hit();
        model_frame();
        g0 = go_count;
        pulse_tick();
        wait_go();
        @(posedge clock); #1 hit_n = 1'b0; tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        @(posedge clock); #1 hit_n = 1'b1;
        wait_idle();
        chk("collapse_gos", go_count - g0, 7);
        chk("collapse_score", score, 3);

        // Reset while waiting on the erase command.
        model_frame();
        pulse_tick();
        wait_go();
        wait_go();
        @(posedge clock); #1 reset = 1'b1;
        #1;
        chk("midrst_draw_go", draw_go, 0);
        chk("midrst_press_pos", press_pos, 1);
        chk("midrst_score", score, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_garb_valid", garb_valid, 0);
        model_reset();
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;

        // Drive score to saturation, then one more hit.
        iter = 0;
        while (mscore < 255 && iter < 3000) begin
            if (mgv && cur_press() == mgpos) do_hit();
            else do_tick();
            iter++;
        end
        chk("sat_reached", score, 255);
        iter = 0;
        while (!(mgv && cur_press() == mgpos) && iter < 12) begin do_tick(); iter++; end
        do_hit();
        chk("sat_hold", score, 255);
        chk("sat_garb_cleared", garb_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
